// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared constants for the PWM fade controller.
//   - mode_e: COLOR / FLASH / STROBE / FADE, encoded as seen on mode_o
//   - OP_*: command opcodes carried on cmd_op
//   - PAL_N and the colour palette (24-bit RGB), plus helpers that scale
//     a palette entry to an arbitrary PWM resolution and channel number
package pwm_fade_pkg;

  typedef enum logic [1:0] {
    MODE_COLOR  = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_STROBE = 2'd2,
    MODE_FADE   = 2'd3
  } mode_e;

  localparam logic [2:0] OP_SET_COLOR = 3'd0;
  localparam logic [2:0] OP_BRIGHT_UP = 3'd1;
  localparam logic [2:0] OP_BRIGHT_DN = 3'd2;
  localparam logic [2:0] OP_OFF       = 3'd3;
  localparam logic [2:0] OP_ON        = 3'd4;
  localparam logic [2:0] OP_FLASH     = 3'd5;
  localparam logic [2:0] OP_STROBE    = 3'd6;
  localparam logic [2:0] OP_FADE      = 3'd7;

  localparam int         PAL_N      = 15;
  localparam int         IDX_W      = 4;
  localparam int         MAX_RES    = 12;
  localparam logic [2:0] BRIGHT_RST = 3'd5;

  // Palette in 24-bit RGB, red in the top byte.
  function automatic logic [23:0] pal_rgb(input logic [IDX_W-1:0] idx);
    logic [23:0] rgb;
    case (idx)
      4'd0:    rgb = 24'hFF0000;
      4'd1:    rgb = 24'h00FF00;
      4'd2:    rgb = 24'h0000FF;
      4'd3:    rgb = 24'hFFFF00;
      4'd4:    rgb = 24'h00FFFF;
      4'd5:    rgb = 24'hFF00FF;
      4'd6:    rgb = 24'hFFFFFF;
      4'd7:    rgb = 24'hFF8000;
      4'd8:    rgb = 24'h8000FF;
      4'd9:    rgb = 24'hFF0080;
      4'd10:   rgb = 24'h80FF00;
      4'd11:   rgb = 24'h008080;
      4'd12:   rgb = 24'h0080FF;
      4'd13:   rgb = 24'h404040;
      4'd14:   rgb = 24'h202020;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  // Channel ch takes R, G, B in rotation (ch 0 = R). The 8-bit component
  // is rescaled so that 0xFF maps to full scale at resolution res.
  function automatic logic [MAX_RES-1:0] pal_value(input logic [IDX_W-1:0] idx,
                                                   input int ch, input int res);
    logic [23:0] rgb;
    logic [7:0]  comp;
    logic [19:0] prod;
    rgb = pal_rgb(idx);
    case (ch % 3)
      0:       comp = rgb[23:16];
      1:       comp = rgb[15:8];
      default: comp = rgb[7:0];
    endcase
    prod = 20'(comp) * 20'((1 << res) - 1);
    return MAX_RES'(prod / 20'd255);
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(PAL_N - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one LED output of the fade controller.
//   clk, rst  : clock, synchronous active-low reset
//   load      : high on the edge that starts a new PWM period
//   duty      : raw duty for this channel (RES bits)
//   bright    : 3-bit brightness level, scales duty by (bright+1)/8
//   cnt       : shared free-running PWM counter
//   an        : 1 = common-anode LED, output inverted
//   pwm_o     : LED drive
module pwm_channel #(
  parameter int RES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [RES-1:0] duty,
  input  logic [2:0]     bright,
  input  logic [RES-1:0] cnt,
  input  logic           an,
  output logic           pwm_o
);

  localparam int             SW   = RES + 3;
  localparam logic [RES-1:0] FULL = '1;

  logic [RES-1:0] d_next;
  logic [RES-1:0] d_q;
  logic           on;

  // duty * (bright + 1) at RES+3 bits, then drop the 3 fraction bits.
  assign d_next = RES'((SW'(duty) * SW'(bright) + SW'(duty)) >> 3);

  // The effective duty only changes at a period boundary so a running
  // period is never cut short or stretched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= '0;
    end else if (load) begin
      d_q <= d_next;
    end
  end

  // Full scale is held on for the whole period; counter < d alone would
  // leave one dark count per period.
  assign on    = (d_q == FULL) || (cnt < d_q);
  assign pwm_o = on ^ an;

endmodule

// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller: multi-channel LED PWM with brightness, on/off and
// palette effects (FLASH, STROBE and, when built with the macro
// PWM_FADE_CONTROLLER_FADE_EN, FADE).
//   clk, rst   : clock, synchronous active-low reset
//   cmd_valid  : command strobe
//   cmd_op     : opcode (pwm_fade_pkg::OP_*)
//   cmd_color  : colour for SET_COLOR, channel 0 in the LSBs
//   cmd_ready  : command acceptance
//   an         : 1 = common-anode LEDs (outputs inverted)
//   pwm_o      : LED drive, one bit per channel
//   mode_o     : current mode (pwm_fade_pkg::mode_e)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is low only while rst is asserted,
// so there is no back-pressure in normal operation.
module pwm_fade_controller
  import pwm_fade_pkg::*;
#(
  parameter int CH       = 3,
  parameter int RES      = 8,
  parameter int TICK_DIV = 30_000_000,
  parameter int FADE_DIV = 65_536
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [2:0]      cmd_op,
  input  logic [CH*RES-1:0] cmd_color,
  output logic            cmd_ready,
  input  logic            an,
  output logic [CH-1:0]   pwm_o,
  output logic [1:0]      mode_o
);

  // One width serves both prescalers.
  localparam int CNT_W = $clog2(((TICK_DIV > FADE_DIV) ? TICK_DIV : FADE_DIV) + 1);
  localparam logic [RES-1:0] CNT_MAX = '1;

  logic [RES-1:0]    cnt_q;
  logic              period_load;
  mode_e             mode_q, mode_n;
  logic              light_q, light_n;
  logic [2:0]        bright_q, bright_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [1:0]        phase_q, phase_n;
  logic [CNT_W-1:0]  tick_q, tick_n;
  logic [CH*RES-1:0] color_q, color_n;
  logic              cmd_fire, live_cmd, cmd_eff;
  logic              tick_run, tick;
  logic [RES-1:0]    pal [CH];
  logic [RES-1:0]    src [CH];

`ifdef PWM_FADE_CONTROLLER_FADE_EN
  logic [CNT_W-1:0]  fade_q, fade_n;
  logic [RES-1:0]    cur_q [CH];
  logic [RES-1:0]    cur_n [CH];
  logic              fade_run, step, all_match;
`endif

  assign cmd_ready = rst;
  assign cmd_fire  = cmd_valid & cmd_ready;
  // While the light is off only ON and brightness commands act.
  assign live_cmd  = cmd_fire & light_q;

  // A command that would change state beats an effect step in the same
  // cycle; an unbuilt FADE opcode is a no-op and does not.
`ifdef PWM_FADE_CONTROLLER_FADE_EN
  assign cmd_eff = cmd_fire;
`else
  assign cmd_eff = cmd_fire && (cmd_op != OP_FADE);
`endif

  // The PWM period starts when the counter wraps; duties load on that edge.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_q + 1'b1;
  end
  assign period_load = (cnt_q == CNT_MAX);

  for (genvar c = 0; c < CH; c++) begin : g_pal
    assign pal[c] = RES'(pal_value(idx_q, c, RES));
  end

  // Effects are frozen while the light is off so ON resumes in place.
  assign tick_run = light_q && ((mode_q == MODE_FLASH) || (mode_q == MODE_STROBE));
  assign tick     = tick_run && (tick_q == CNT_W'(TICK_DIV - 1));

`ifdef PWM_FADE_CONTROLLER_FADE_EN
  assign fade_run = light_q && (mode_q == MODE_FADE);
  assign step     = fade_run && (fade_q == CNT_W'(FADE_DIV - 1));

  always_comb begin
    all_match = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if (cur_q[c] != pal[c]) all_match = 1'b0;
    end
  end
`endif

  // ---------------- mode FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) mode_q <= MODE_COLOR;
    else      mode_q <= mode_n;
  end

  // ---------------- mode FSM: next state ----------------
  always_comb begin
    mode_n = mode_q;
    if (live_cmd) begin
      case (cmd_op)
        OP_SET_COLOR: mode_n = MODE_COLOR;
        OP_FLASH:     mode_n = MODE_FLASH;
        OP_STROBE:    mode_n = MODE_STROBE;
`ifdef PWM_FADE_CONTROLLER_FADE_EN
        OP_FADE:      mode_n = MODE_FADE;
`endif
        default:      mode_n = mode_q;
      endcase
    end
  end

  // ---------------- mode FSM: outputs ----------------
  always_comb begin
    mode_o = mode_q;
    for (int c = 0; c < CH; c++) begin
      src[c] = '0;
      if (light_q) begin
        case (mode_q)
          MODE_COLOR:  src[c] = color_q[c*RES +: RES];
          MODE_FLASH:  src[c] = pal[c];
          MODE_STROBE: src[c] = (phase_q == 2'd0) ? pal[c] : '0;
`ifdef PWM_FADE_CONTROLLER_FADE_EN
          MODE_FADE:   src[c] = cur_q[c];
`endif
          default:     src[c] = '0;
        endcase
      end
    end
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    light_n  = light_q;
    bright_n = bright_q;
    color_n  = color_q;
    idx_n    = idx_q;
    phase_n  = phase_q;
    tick_n   = tick_q;
`ifdef PWM_FADE_CONTROLLER_FADE_EN
    fade_n   = fade_q;
    for (int c = 0; c < CH; c++) cur_n[c] = cur_q[c];
`endif

    if (tick_run) tick_n = tick ? '0 : tick_q + 1'b1;

    if (tick && !cmd_eff) begin
      if (mode_q == MODE_FLASH) begin
        idx_n = next_idx(idx_q);
      end else begin
        // STROBE: one lit phase, three dark; next colour after the last.
        phase_n = phase_q + 2'd1;
        if (phase_q == 2'd3) idx_n = next_idx(idx_q);
      end
    end

`ifdef PWM_FADE_CONTROLLER_FADE_EN
    if (fade_run) fade_n = step ? '0 : fade_q + 1'b1;

    // A step either nudges every channel toward its target or, once all
    // have arrived, moves on to the next palette entry.
    if (step && !cmd_eff) begin
      if (all_match) begin
        idx_n = next_idx(idx_q);
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (cur_q[c] < pal[c])      cur_n[c] = cur_q[c] + 1'b1;
          else if (cur_q[c] > pal[c]) cur_n[c] = cur_q[c] - 1'b1;
        end
      end
    end
`endif

    if (cmd_fire) begin
      case (cmd_op)
        OP_BRIGHT_UP: if (bright_q != 3'd7) bright_n = bright_q + 3'd1;
        OP_BRIGHT_DN: if (bright_q != 3'd0) bright_n = bright_q - 3'd1;
        OP_OFF:       light_n = 1'b0;
        OP_ON:        light_n = 1'b1;
        OP_SET_COLOR: if (light_q) color_n = cmd_color;
        OP_FLASH, OP_STROBE: begin
          if (light_q) begin
            idx_n   = '0;
            phase_n = '0;
            tick_n  = '0;
`ifdef PWM_FADE_CONTROLLER_FADE_EN
            fade_n  = '0;
`endif
          end
        end
`ifdef PWM_FADE_CONTROLLER_FADE_EN
        // Fading starts from dark and ramps toward palette entry 0.
        OP_FADE: begin
          if (light_q) begin
            idx_n   = '0;
            phase_n = '0;
            tick_n  = '0;
            fade_n  = '0;
            for (int c = 0; c < CH; c++) cur_n[c] = '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      light_q  <= 1'b1;
      bright_q <= BRIGHT_RST;
      color_q  <= '1;
      idx_q    <= '0;
      phase_q  <= '0;
      tick_q   <= '0;
`ifdef PWM_FADE_CONTROLLER_FADE_EN
      fade_q   <= '0;
      for (int c = 0; c < CH; c++) cur_q[c] <= '0;
`endif
    end else begin
      light_q  <= light_n;
      bright_q <= bright_n;
      color_q  <= color_n;
      idx_q    <= idx_n;
      phase_q  <= phase_n;
      tick_q   <= tick_n;
`ifdef PWM_FADE_CONTROLLER_FADE_EN
      fade_q   <= fade_n;
      for (int c = 0; c < CH; c++) cur_q[c] <= cur_n[c];
`endif
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    pwm_channel #(.RES(RES)) u_channel (
      .clk    (clk),
      .rst    (rst),
      .load   (period_load),
      .duty   (src[c]),
      .bright (bright_q),
      .cnt    (cnt_q),
      .an     (an),
      .pwm_o  (pwm_o[c])
    );
  end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Bench for pwm_fade_controller: directed scenarios followed by random
// commands, resets and polarity flips, checked cycle by cycle against a
// behavioural model of the LED controller.
module tb_pwm_fade_controller;

  localparam int CH       = 3;
  localparam int RES      = 4;
  localparam int TICK_DIV = 4;
  localparam int FADE_DIV = 1;
  localparam int MAXV     = (1 << RES) - 1;
  localparam int PAL_N    = 15;
`ifdef PWM_FADE_CONTROLLER_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [2:0]        cmd_op = 3'd0;
  logic [CH*RES-1:0] cmd_color = '0;
  logic              cmd_ready;
  logic              an = 1'b0;
  logic [CH-1:0]     pwm_o;
  logic [1:0]        mode_o;

  always #5 clk = ~clk;

  pwm_fade_controller #(
    .CH(CH), .RES(RES), .TICK_DIV(TICK_DIV), .FADE_DIV(FADE_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_color (cmd_color),
    .cmd_ready (cmd_ready),
    .an        (an),
    .pwm_o     (pwm_o),
    .mode_o    (mode_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int pal_rgb [PAL_N] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h00FFFF,
    24'hFF00FF, 24'hFFFFFF, 24'hFF8000, 24'h8000FF, 24'hFF0080,
    24'h80FF00, 24'h008080, 24'h0080FF, 24'h404040, 24'h202020};

  // model state: mode 0 COLOR, 1 FLASH, 2 STROBE, 3 FADE
  int m_cnt, m_bright, m_on, m_mode, m_idx, m_phase, m_tick, m_fade;
  int m_color [CH];
  int m_cur   [CH];
  int m_d     [CH];

  logic [CH+1:0] exp_q [$];

  function automatic int pal_val(input int idx, input int c);
    int comp;
    comp = (pal_rgb[idx] >> (16 - 8 * (c % 3))) & 255;
    return comp * MAXV / 255;
  endfunction

  function automatic int src_duty(input int c);
    if (m_on == 0) return 0;
    case (m_mode)
      0:       return m_color[c];
      1:       return pal_val(m_idx, c);
      2:       return (m_phase == 0) ? pal_val(m_idx, c) : 0;
      default: return m_cur[c];
    endcase
  endfunction

  task automatic model_step();
    bit tick_now, step_now, cmd_hit, match;
    if (!rst) begin
      m_cnt = 0; m_bright = 5; m_on = 1; m_mode = 0;
      m_idx = 0; m_phase = 0; m_tick = 0; m_fade = 0;
      for (int c = 0; c < CH; c++) begin
        m_color[c] = MAXV; m_cur[c] = 0; m_d[c] = 0;
      end
      return;
    end
    // a new period begins: latch brightness-scaled duties from the old state
    if (m_cnt == MAXV)
      for (int c = 0; c < CH; c++) m_d[c] = src_duty(c) * (m_bright + 1) / 8;

    cmd_hit = cmd_valid && (FADE_EN || cmd_op != 3'd7);

    tick_now = (m_on != 0) && (m_mode == 1 || m_mode == 2) && (m_tick == TICK_DIV - 1);
    if ((m_on != 0) && (m_mode == 1 || m_mode == 2)) m_tick = tick_now ? 0 : m_tick + 1;
    if (tick_now && !cmd_hit) begin
      if (m_mode == 1) m_idx = (m_idx + 1) % PAL_N;
      else begin
        if (m_phase == 3) m_idx = (m_idx + 1) % PAL_N;
        m_phase = (m_phase + 1) % 4;
      end
    end

    step_now = (m_on != 0) && (m_mode == 3) && (m_fade == FADE_DIV - 1);
    if ((m_on != 0) && (m_mode == 3)) m_fade = step_now ? 0 : m_fade + 1;
    if (step_now && !cmd_hit) begin
      match = 1'b1;
      for (int c = 0; c < CH; c++) if (m_cur[c] != pal_val(m_idx, c)) match = 1'b0;
      if (match) m_idx = (m_idx + 1) % PAL_N;
      else
        for (int c = 0; c < CH; c++) begin
          if (m_cur[c] < pal_val(m_idx, c)) m_cur[c]++;
          else if (m_cur[c] > pal_val(m_idx, c)) m_cur[c]--;
        end
    end

    if (cmd_valid) begin
      case (cmd_op)
        3'd0: if (m_on != 0) begin
          for (int c = 0; c < CH; c++) m_color[c] = (cmd_color >> (c * RES)) & MAXV;
          m_mode = 0;
        end
        3'd1: if (m_bright < 7) m_bright++;
        3'd2: if (m_bright > 0) m_bright--;
        3'd3: m_on = 0;
        3'd4: m_on = 1;
        3'd5, 3'd6: if (m_on != 0) begin
          m_mode = cmd_op - 4; m_idx = 0; m_phase = 0; m_tick = 0; m_fade = 0;
        end
        default: if (m_on != 0 && FADE_EN) begin
          m_mode = 3; m_idx = 0; m_phase = 0; m_tick = 0; m_fade = 0;
          for (int c = 0; c < CH; c++) m_cur[c] = 0;
        end
      endcase
    end
    m_cnt = (m_cnt + 1) % (MAXV + 1);
  endtask

  function automatic logic [CH+1:0] model_out();
    logic [CH-1:0] p;
    for (int c = 0; c < CH; c++)
      p[c] = ((m_d[c] == MAXV) || (m_cnt < m_d[c])) ^ an;
    return {2'(m_mode), p};
  endfunction

  always @(posedge clk) begin
    model_step();
    exp_q.push_back(model_out());
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [CH+1:0] e;
    @(negedge clk);
    check("exp_q_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pwm_o", int'(pwm_o), int'(e[CH-1:0]));
      check("mode_o", int'(mode_o), int'(e[CH+1:CH]));
    end
    check("cmd_ready", int'(cmd_ready), int'(rst));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [2:0] op, input logic [CH*RES-1:0] col);
    cmd_valid = 1'b1; cmd_op = op; cmd_color = col;
    cycle();
    cmd_valid = 1'b0;
  endtask

  // High cycles of each channel over one full period (duty is periodic).
  task automatic window(output int hi [CH]);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    for (int i = 0; i <= MAXV; i++) begin
      cycle();
      for (int c = 0; c < CH; c++) hi[c] += int'(pwm_o[c]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi [CH];
    int r;
    rst = 1'b0; an = 1'b0;
    run(3);
    rst = 1'b1;

    // colour R=8 G=0 B=15 at full brightness
    send(3'd0, {4'hF, 4'h0, 4'h8});
    send(3'd1, '0);
    send(3'd1, '0);
    run(40);
    window(hi);
    check("r_high_b7", hi[0], 8);
    check("g_high_b7", hi[1], 0);
    check("b_high_b7", hi[2], 16);
    an = 1'b1;
    window(hi);
    check("r_high_an", hi[0], 8);
    check("g_high_an", hi[1], 16);
    check("b_high_an", hi[2], 0);
    an = 1'b0;

    // brightness floor
    repeat (7) send(3'd2, '0);
    run(40);
    window(hi);
    check("r_high_b0", hi[0], 1);
    check("b_high_b0", hi[2], 1);
    send(3'd2, '0);
    run(40);
    window(hi);
    check("r_high_b0_sat", hi[0], 1);
    repeat (7) send(3'd1, '0);

    // FLASH with OFF/ON in the middle
    send(3'd5, '0);
    run(130);
    send(3'd3, '0);
    run(40);
    window(hi);
    check("off_dark", hi[0] + hi[1] + hi[2], 0);
    send(3'd4, '0);
    run(80);

    // STROBE, then SET_COLOR at an arbitrary tick alignment
    send(3'd6, '0);
    run(100 + $urandom_range(0, 7));
    send(3'd0, 12'($urandom));
    run(40);

    // FADE (a no-op opcode when the fade datapath is not built)
    send(3'd7, '0);
    run(300);
    rst = 1'b0;
    run(2);
    rst = 1'b1;
    run(20);

    // random commands, resets and polarity flips
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 299);
      if (r < 24) begin
        send(3'($urandom_range(0, 7)), 12'($urandom));
      end else if (r == 24) begin
        rst = 1'b0;
        cycle();
        rst = 1'b1;
      end else if (r == 25) begin
        an = ~an;
        cycle();
      end else begin
        cycle();
      end
    end

    run(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_controller.md
PWM_FADE_CONTROLLER -- requirements
Module: pwm_fade_controller

Interface
REQ-001 Parameter CH, default 3, number of independent LED channels (1..8).
REQ-002 Parameter RES, default 8, PWM resolution in bits (4..12).
REQ-003 Parameter TICK_DIV, default 30_000_000, clock cycles per effect tick (FLASH/STROBE).
REQ-004 Parameter FADE_DIV, default 65_536, clock cycles per fade step (FADE).
REQ-005 Port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-low.
REQ-007 Port cmd_valid  input  1  single-cycle command strobe.
REQ-008 Port cmd_op  input  3  opcode: 0 SET_COLOR, 1 BRIGHT_UP, 2 BRIGHT_DN, 3 OFF, 4 ON, 5 FLASH, 6 STROBE, 7 FADE.
REQ-009 Port cmd_color  input  CH*RES  colour for SET_COLOR; channel 0 in LSBs.
REQ-010 Port cmd_ready  output  1  command accepted this cycle when cmd_valid & cmd_ready.
REQ-011 Port an  input  1  high = common-anode LED (outputs inverted), low = common-cathode.
REQ-012 Port pwm_o  output  CH  LED drive, one bit per channel.
REQ-013 Port mode_o  output  2  current mode: 0 COLOR, 1 FLASH, 2 STROBE, 3 FADE.

Function
REQ-014 Free-running RES-bit PWM counter wraps 2^RES-1 -> 0; sync = counter==0.
REQ-015 Per-channel effective duty d = (duty * (bright+1)) >> 3, computed at RES+3 bits, truncated to RES bits.
REQ-016 Effective duty is sampled only at sync; mid-period changes never glitch the current period.
REQ-017 Channel on when counter < d, or d == 2^RES-1 (fully on); d == 0 is fully off; pwm_o = on XOR an.
REQ-018 cmd_ready is 1 in every cycle except reset; accepted commands update state on the next clock edge; effect visible at pwm_o from the next sync.
REQ-019 SET_COLOR loads cmd_color into the colour register and forces mode COLOR.
REQ-020 BRIGHT_UP/BRIGHT_DN move the 3-bit level bright by 1, saturating at 7 and 0.
REQ-021 OFF clears light_on; while light_on = 0, pwm_o = {CH{an}} and all opcodes except ON and BRIGHT_UP/BRIGHT_DN are ignored.
REQ-022 ON sets light_on; mode, colour and palette index are preserved across OFF/ON.
REQ-023 FLASH/STROBE/FADE opcodes set the mode, clear the prescalers, palette index = 0, strobe phase = 0.
REQ-024 Tick prescaler runs only in FLASH/STROBE; it pulses one cycle every TICK_DIV cycles.
REQ-025 FLASH: each tick advances palette index 0..PAL_N-1, wrapping to 0; duty = palette entry.
REQ-026 STROBE: 2-bit phase increments each tick; phase 0 shows the palette entry, phases 1-3 dark; index advances on the phase 3 -> 0 transition.
REQ-027 FADE: every FADE_DIV cycles each channel's current value moves 1 LSB toward the target palette entry; when all channels equal their targets, the index advances (wrapping).
REQ-028 Simultaneous command and tick/fade step in one cycle: the command wins and the tick is discarded.

Reset
REQ-029 rst low at a clock edge: counter 0, colour all ones, bright 5, light_on 1, mode COLOR (mode_o 0), index 0, phase 0, prescalers 0, cmd_ready 0.
REQ-030 pwm_o = {CH{an}} while in reset; reset mid-fade or mid-strobe abandons the effect with no residual state.

Configuration
REQ-031 Macro PWM_FADE_CONTROLLER_FADE_EN defined: FADE mode and the fade datapath are built as specified.
REQ-032 Macro undefined: no fade logic; opcode 7 is ignored (no state change, still accepted); mode_o never shows 3.

Structure
REQ-033 Package pwm_fade_pkg holds the mode and opcode constants, PAL_N = 15, and the palette table (24-bit RGB entries scaled to RES and CH).
REQ-034 Sub-module pwm_channel (duty sample at sync, brightness scale, compare, an polarity) is instantiated CH times via generate.

Verification
REQ-035 Reset, then SET_COLOR {R=0x80,G=0x00,B=0xFF} with bright 7: R high 128/256 cycles, G never high, B high continuously; an=1 inverts all three.
REQ-036 Five BRIGHT_DN, then two more: bright sticks at 0; R duty 0x80 gives d=16; an eighth command gives no change.
REQ-037 TICK_DIV=4, FLASH: index advances every 4 cycles, 14 -> 0 wrap observed; OFF mid-sequence gives pwm_o={CH{an}}; ON resumes at the same index.
REQ-038 TICK_DIV=2, STROBE: lit for 1 tick, dark for 3, index +1 per 4 ticks; a SET_COLOR landing on a tick edge gives mode COLOR with no index change.
REQ-039 FADE_EN, FADE_DIV=1, RES=4: channel values step by 1 per cycle toward the target; the index advances once all match; rst low mid-fade gives all reset values next cycle.
REQ-040 FADE_EN undefined: opcode 7 leaves mode_o and pwm_o unchanged; cmd_ready stays 1.
